// File: rtl/grad_accumulator_pkg.sv
// Shared types for the mini-batch gradient accumulator: the element data
// type used on both stream interfaces and the two-state control enum.
package grad_accumulator_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] data_type;

  typedef enum logic {
    ACCUM,
    DRAIN
  } acc_state_t;

endpackage

// File: rtl/grad_accumulator.sv
// Mini-batch gradient accumulator. Sums 2^LOG2_BATCH samples of DEPTH
// gradient elements element-wise, then streams out the batch mean (floored
// arithmetic shift) one element per handshake, in the same element order.
module grad_accumulator
  import grad_accumulator_pkg::*;
#(
  parameter int DEPTH      = 15,
  parameter int LOG2_BATCH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  data_type                 in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output data_type                 out_data,
  output logic [$clog2(DEPTH)-1:0] out_index,
  output logic                     out_last
);

  // The sum of 2^LOG2_BATCH values of DATA_W bits always fits in this width.
  localparam int ACC_W = DATA_W + LOG2_BATCH;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [LOG2_BATCH-1:0] SMP_LAST = '1;

  acc_state_t              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [LOG2_BATCH-1:0]   smp_q, smp_d;
  logic signed [ACC_W-1:0] acc_q [DEPTH];

  logic                    inFire;
  logic                    outFire;
  logic                    idxAtLast;
  logic signed [ACC_W-1:0] inExt;
  logic signed [ACC_W-1:0] accSum;

  // Handshake flags depend only on registered state, never on the valid/ready
  // inputs, so there is no combinational path through the block.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DRAIN);
  assign inFire    = in_valid && in_ready;
  assign outFire   = out_valid && out_ready;
  assign idxAtLast = (idx_q == IDX_LAST);

  // The first sample of a batch overwrites the slot, so the previous batch
  // never needs an explicit clear pass.
  assign inExt  = {{LOG2_BATCH{in_data[DATA_W-1]}}, in_data};
  assign accSum = (smp_q == '0) ? inExt : (acc_q[idx_q] + inExt);

  // Taking the upper DATA_W bits of the accumulator is the arithmetic right
  // shift by LOG2_BATCH truncated to DATA_W, i.e. the mean floored to -inf.
  assign out_data  = acc_q[idx_q][ACC_W-1:LOG2_BATCH];
  assign out_index = idx_q;
  assign out_last  = out_valid && idxAtLast;

  // Control registers; reset discards any partial batch or drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      smp_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      smp_q   <= smp_d;
    end
  end

  // Single read/modify/write port into the accumulator array at idx.
  always_ff @(posedge clk) begin
    if (!rst && inFire) begin
      acc_q[idx_q] <= accSum;
    end
  end

  // Next-state logic: walk idx/smp through the batch, then idx through the drain.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    smp_d   = smp_q;
    unique case (state_q)
      ACCUM: begin
        if (inFire) begin
          if (idxAtLast) begin
            idx_d = '0;
            if (smp_q == SMP_LAST) begin
              smp_d   = '0;
              state_d = DRAIN;
            end else begin
              smp_d = smp_q + LOG2_BATCH'(1);
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (outFire) begin
          if (idxAtLast) begin
            idx_d   = '0;
            state_d = ACCUM;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

endmodule
